// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select.
module multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         opcode_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [2:0]         alu_op_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               halted_o,
  output logic [COUNT_W-1:0] inst_count_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               retire;
  logic [COUNT_W-1:0] count;

  assign inst_count_o = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (retire) count <= count + COUNT_W'(1);
    end
  end

  // Reset clears the state register asynchronously, so every output below
  // collapses to zero in the same cycle the reset is asserted.
  always_comb begin
    next_state   = state;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    halted_o     = 1'b0;

    case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_J: begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'b10;
            retire     = 1'b1;
            next_state = FETCH;
          end
          OP_HALT: next_state = HALT;
          OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW: next_state = EXEC;
          default: begin
            retire     = 1'b1;
            next_state = FETCH;
          end
        endcase
      end

      EXEC: begin
        alu_src_a_o = 1'b1;
        case (opcode_i)
          OP_RTYPE: begin
            alu_op_o   = 3'b010;
            next_state = WB;
          end
          OP_ADDI: begin
            alu_src_b_o = 2'b10;
            next_state  = WB;
          end
          OP_SLTI: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b011;
            next_state  = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b_o = 2'b10;
            next_state  = MEM;
          end
          OP_BEQ: begin
            alu_op_o   = 3'b001;
            pc_src_o   = 2'b01;
            pc_write_o = zero_i;
            retire     = 1'b1;
            next_state = FETCH;
          end
          default: next_state = FETCH;
        endcase
      end

      MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (opcode_i == OP_SW);
        if (mem_ready_i) begin
          if (opcode_i == OP_SW) begin
            retire     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end
      end

      WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (opcode_i == OP_RTYPE);
        mem_to_reg_o = (opcode_i == OP_LW);
        retire       = 1'b1;
        next_state   = FETCH;
      end

      HALT: halted_o = 1'b1;

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_UNDEF = 6'b010101;

  // Bit order: req we irw pcw pcsrc[2] a b[2] aluop[3] rdst m2r rw halted
  localparam logic [15:0] V_IDLE    = 16'b0_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [15:0] V_FWAIT   = 16'b1_0_0_0_00_0_01_000_0_0_0_0;
  localparam logic [15:0] V_FETCH   = 16'b1_0_1_1_00_0_01_000_0_0_0_0;
  localparam logic [15:0] V_DEC     = 16'b0_0_0_0_00_0_11_000_0_0_0_0;
  localparam logic [15:0] V_DEC_J   = 16'b0_0_0_1_10_0_11_000_0_0_0_0;
  localparam logic [15:0] V_EX_R    = 16'b0_0_0_0_00_1_00_010_0_0_0_0;
  localparam logic [15:0] V_EX_IMM  = 16'b0_0_0_0_00_1_10_000_0_0_0_0;
  localparam logic [15:0] V_EX_SLT  = 16'b0_0_0_0_00_1_10_011_0_0_0_0;
  localparam logic [15:0] V_EX_BEQ1 = 16'b0_0_0_1_01_1_00_001_0_0_0_0;
  localparam logic [15:0] V_EX_BEQ0 = 16'b0_0_0_0_01_1_00_001_0_0_0_0;
  localparam logic [15:0] V_MEM_LW  = 16'b1_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [15:0] V_MEM_SW  = 16'b1_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [15:0] V_WB_R    = 16'b0_0_0_0_00_0_00_000_1_0_1_0;
  localparam logic [15:0] V_WB_I    = 16'b0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [15:0] V_WB_LW   = 16'b0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [15:0] V_HALT    = 16'b0_0_0_0_00_0_00_000_0_0_0_1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, ir_write, pc_write, alu_src_a;
  logic        reg_dst, mem_to_reg, reg_write, halted;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] count32;

  logic        n_mem_req, n_mem_we, n_ir_write, n_pc_write, n_alu_src_a;
  logic        n_reg_dst, n_mem_to_reg, n_reg_write, n_halted;
  logic [1:0]  n_pc_src, n_alu_src_b;
  logic [2:0]  n_alu_op;
  logic [3:0]  count4;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .halted_o(halted), .inst_count_o(count32)
  );

  multicycle_ctrl #(.COUNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(n_mem_req), .mem_we_o(n_mem_we),
    .ir_write_o(n_ir_write), .pc_write_o(n_pc_write), .pc_src_o(n_pc_src),
    .alu_src_a_o(n_alu_src_a), .alu_src_b_o(n_alu_src_b), .alu_op_o(n_alu_op),
    .reg_dst_o(n_reg_dst), .mem_to_reg_o(n_mem_to_reg), .reg_write_o(n_reg_write),
    .halted_o(n_halted), .inst_count_o(count4)
  );

  logic [15:0] act_vec, act_vec4;
  assign act_vec  = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, halted};
  assign act_vec4 = {n_mem_req, n_mem_we, n_ir_write, n_pc_write, n_pc_src, n_alu_src_a,
                     n_alu_src_b, n_alu_op, n_reg_dst, n_mem_to_reg, n_reg_write, n_halted};

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_item;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_count = 32'd0;

  task automatic checkOutput(input exp_t e);
    total++;
    if (act_vec !== e.vec) begin
      bad++;
      $display("[TB] FAIL %s outputs: got %b expected %b", e.tag, act_vec, e.vec);
    end
    total++;
    if (count32 !== e.cnt) begin
      bad++;
      $display("[TB] FAIL %s count: got %0d expected %0d", e.tag, count32, e.cnt);
    end
    total++;
    if (act_vec4 !== e.vec) begin
      bad++;
      $display("[TB] FAIL %s outputs_w4: got %b expected %b", e.tag, act_vec4, e.vec);
    end
    total++;
    if (count4 !== e.cnt[3:0]) begin
      bad++;
      $display("[TB] FAIL %s count_w4: got %0d expected %0d", e.tag, count4, e.cnt[3:0]);
    end
  endtask

  // Monitor: one expected entry is queued per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_item = sb_q.pop_front();
      checkOutput(mon_item);
    end
  end

  task automatic push_exp(input logic [15:0] v, input bit ret, input string tag);
    exp_t e;
    e.vec = v;
    e.cnt = exp_count;
    e.tag = tag;
    sb_q.push_back(e);
    if (ret) exp_count = exp_count + 32'd1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy,
                               input logic [15:0] v, input bit ret, input string tag);
    @(posedge clk);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    push_exp(v, ret, tag);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst       = 1'b1;
      mem_ready = 1'b0;
      exp_count = 32'd0;
      push_exp(V_IDLE, 1'b0, "reset");
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    push_exp(V_IDLE, 1'b0, "idle");
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fwaits, input int mwaits);
    for (int i = 0; i < fwaits; i++) applyStimulus(op, z, 1'b0, V_FWAIT, 1'b0, "fetch_wait");
    applyStimulus(op, z, 1'b1, V_FETCH, 1'b0, "fetch");
    case (op)
      OP_J:    applyStimulus(op, z, 1'b1, V_DEC_J, 1'b1, "decode_j");
      OP_HALT: applyStimulus(op, z, 1'b1, V_DEC, 1'b0, "decode_halt");
      OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW:
               applyStimulus(op, z, 1'b1, V_DEC, 1'b0, "decode");
      default: applyStimulus(op, z, 1'b1, V_DEC, 1'b1, "decode_nop");
    endcase
    case (op)
      OP_R: begin
        applyStimulus(op, z, 1'b1, V_EX_R, 1'b0, "exec_r");
        applyStimulus(op, z, 1'b1, V_WB_R, 1'b1, "wb_r");
      end
      OP_ADDI: begin
        applyStimulus(op, z, 1'b1, V_EX_IMM, 1'b0, "exec_addi");
        applyStimulus(op, z, 1'b1, V_WB_I, 1'b1, "wb_addi");
      end
      OP_SLTI: begin
        applyStimulus(op, z, 1'b1, V_EX_SLT, 1'b0, "exec_slti");
        applyStimulus(op, z, 1'b1, V_WB_I, 1'b1, "wb_slti");
      end
      OP_BEQ: applyStimulus(op, z, 1'b1, z ? V_EX_BEQ1 : V_EX_BEQ0, 1'b1, "exec_beq");
      OP_LW: begin
        applyStimulus(op, z, 1'b1, V_EX_IMM, 1'b0, "exec_lw");
        for (int i = 0; i < mwaits; i++) applyStimulus(op, z, 1'b0, V_MEM_LW, 1'b0, "mem_lw_wait");
        applyStimulus(op, z, 1'b1, V_MEM_LW, 1'b0, "mem_lw");
        applyStimulus(op, z, 1'b1, V_WB_LW, 1'b1, "wb_lw");
      end
      OP_SW: begin
        applyStimulus(op, z, 1'b1, V_EX_IMM, 1'b0, "exec_sw");
        for (int i = 0; i < mwaits; i++) applyStimulus(op, z, 1'b0, V_MEM_SW, 1'b0, "mem_sw_wait");
        applyStimulus(op, z, 1'b1, V_MEM_SW, 1'b1, "mem_sw");
      end
      default: ;
    endcase
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting multicycle_ctrl sequence");
    do_reset(2);
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 3);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_UNDEF, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 2, 0);
    run_instr(OP_SLTI, 1'b1, 0, 0);
    run_instr(OP_SW, 1'b0, 0, 1);
    // Eight more retirements take the 4-bit counter through its wrap.
    for (int i = 0; i < 8; i++) run_instr(6'(6'b110000 + i), 1'b0, 0, 0);
    run_instr(OP_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(OP_HALT, 1'b0, 1'(i % 2), V_HALT, 1'b0, "halt");

    do_reset(1);
    applyStimulus(OP_SW, 1'b0, 1'b1, V_FETCH, 1'b0, "fetch");
    applyStimulus(OP_SW, 1'b0, 1'b1, V_DEC, 1'b0, "decode");
    applyStimulus(OP_SW, 1'b0, 1'b1, V_EX_IMM, 1'b0, "exec_sw");
    applyStimulus(OP_SW, 1'b0, 1'b0, V_MEM_SW, 1'b0, "mem_sw_wait");
    applyStimulus(OP_SW, 1'b0, 1'b0, V_MEM_SW, 1'b0, "mem_sw_wait");
    do_reset(2);
    run_instr(OP_SW, 1'b0, 0, 0);
    run_instr(OP_R, 1'b0, 0, 0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
